// File: rtl/twitchcore_pkg.sv
// Shared types and constants for the twitchcore data-memory responder.
package twitchcore_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] TOHOST_ADDR_DEF = 32'h0000_F000;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core data port and dmem_responder.
interface dmem_responder_if;
  import twitchcore_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane write enables and combinational read.
module dmem_array
  import twitchcore_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wstrb,
  output logic [XLEN-1:0] rdata
);

  // Not reset: contents survive reset so benches can preload them.
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait, TOHOST halt.
//   state | meaning
//   IDLE  | ready for a request; req_ready=1
//   WAIT  | counting down the access wait
//   RESP  | response held until rsp_ready
module dmem_responder
  import twitchcore_pkg::*;
#(
  parameter int              DEPTH_WORDS = 4096,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0] TOHOST_ADDR = TOHOST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic              halt,
  output logic [XLEN-1:0]   halt_code
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  dmem_state_t       state;
  logic [WAIT_W-1:0] cnt;
  logic              l_we;
  logic [XLEN-1:0]   l_addr;
  logic [XLEN-1:0]   l_wdata;
  logic [3:0]        l_wstrb;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;
  logic              halt_q;
  logic [XLEN-1:0]   halt_code_q;

  logic              cur_we;
  logic [XLEN-1:0]   cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic [3:0]        cur_wstrb;
  logic              is_tohost;
  logic              in_ram;
  logic              access_go;
  logic              ram_we;
  logic [XLEN-1:0]   ram_rdata;
  logic [XLEN-1:0]   rdata_nx;
  logic              err_nx;

  // With no wait the access happens on the accepting edge, so decode the live request.
  always_comb begin
    cur_we    = l_we;
    cur_addr  = l_addr;
    cur_wdata = l_wdata;
    cur_wstrb = l_wstrb;
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_wstrb = bus.req_wstrb;
    end
  end

  always_comb begin
    is_tohost = (cur_addr == TOHOST_ADDR);
    in_ram    = ({1'b0, cur_addr} < RAM_BYTES) && !is_tohost;
    access_go = ((state == WAIT) && (cnt == '0)) ||
                ((state == IDLE) && bus.req_valid && (WAIT_CYCLES == 0));
    ram_we    = access_go && cur_we && in_ram;
    err_nx    = !is_tohost && !in_ram;
    rdata_nx  = '0;
    if (!cur_we) begin
      if (is_tohost)   rdata_nx = {{(XLEN-1){1'b0}}, halt_q};
      else if (in_ram) rdata_nx = ram_rdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .wstrb (cur_wstrb),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      l_we        <= 1'b0;
      l_addr      <= '0;
      l_wdata     <= '0;
      l_wstrb     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we        <= bus.req_we;
            l_addr      <= bus.req_addr;
            l_wdata     <= bus.req_wdata;
            l_wstrb     <= bus.req_wstrb;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (access_go) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_nx;
        rsp_err_q   <= err_nx;
        // Only the first TOHOST store defines the exit code.
        if (cur_we && is_tohost && !halt_q) begin
          halt_q      <= 1'b1;
          halt_code_q <= cur_wdata;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign halt          = halt_q;
  assign halt_code     = halt_code_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYCLES=1 instance for main traffic, WAIT_CYCLES=3 for mid-wait reset.
module tb_dmem_responder;
  import twitchcore_pkg::*;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  logic        halt_a, halt_b;
  logic [31:0] halt_code_a, halt_code_b;

  dmem_responder #(.WAIT_CYCLES(1)) dut (
    .clk (clk), .reset (reset_a), .bus (ifa.slave),
    .halt (halt_a), .halt_code (halt_code_a)
  );

  dmem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk (clk), .reset (reset_b), .bus (ifb.slave),
    .halt (halt_b), .halt_code (halt_code_b)
  );

  // Shared driver, steered to one instance by use_b.
  logic        use_b = 1'b0;
  logic        drv_valid = 1'b0, drv_we = 1'b0, drv_rready = 1'b0;
  logic [31:0] drv_addr = '0, drv_wdata = '0;
  logic [3:0]  drv_wstrb = '0;

  assign ifa.req_valid = drv_valid && !use_b;
  assign ifb.req_valid = drv_valid && use_b;
  assign ifa.rsp_ready = drv_rready && !use_b;
  assign ifb.rsp_ready = drv_rready && use_b;
  assign ifa.req_we    = drv_we;
  assign ifb.req_we    = drv_we;
  assign ifa.req_addr  = drv_addr;
  assign ifb.req_addr  = drv_addr;
  assign ifa.req_wdata = drv_wdata;
  assign ifb.req_wdata = drv_wdata;
  assign ifa.req_wstrb = drv_wstrb;
  assign ifb.req_wstrb = drv_wstrb;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_halt;
  logic [31:0] o_rsp_rdata, o_halt_code;
  assign o_req_ready = use_b ? ifb.req_ready : ifa.req_ready;
  assign o_rsp_valid = use_b ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_rsp_rdata = use_b ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign o_rsp_err   = use_b ? ifb.rsp_err   : ifa.rsp_err;
  assign o_halt      = use_b ? halt_b        : halt_a;
  assign o_halt_code = use_b ? halt_code_b   : halt_code_a;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for rsp_valid; lat counts edges after the accepting edge.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                     output int lat);
    logic got;
    @(negedge clk);
    chk("accept_ready", o_req_ready, 1);
    drv_valid = 1'b1; drv_we = we; drv_addr = addr; drv_wdata = wdata; drv_wstrb = wstrb;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = o_rsp_valid;
    end
    if (!got) chk("rsp_timeout", 0, 1);
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    drv_rready = 1'b1;
    @(posedge clk); #1;
    drv_rready = 1'b0;
    chk("rsp_dropped", o_rsp_valid, 0);
    chk("idle_ready", o_req_ready, 1);
  endtask

  logic [31:0] rd, hold_rd;
  logic        er;
  int          lat;

  initial begin
    dut.u_array.mem[16] = 32'hDEAD_BEEF;
    dut.u_array.mem[0]  = 32'h0BAD_F00D;
    dut3.u_array.mem[5] = 32'hCAFE_0005;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    chk("rst_halt", o_halt, 0);
    chk("rst_halt_code", o_halt_code, 0);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;

    req(1'b0, 32'h40, 0, 4'h0, rd, er, lat);
    chk("ld40_latency", lat, 2);
    chk("ld40_rdata", rd, 32'hDEAD_BEEF);
    chk("ld40_err", er, 0);
    finish_rsp();

    req(1'b1, 32'h40, 32'h1122_3344, 4'b0101, rd, er, lat);
    chk("st40_rdata", rd, 0);
    chk("st40_err", er, 0);
    finish_rsp();
    req(1'b0, 32'h40, 0, 4'h0, rd, er, lat);
    chk("ld40_merged", rd, 32'hDE22_BE44);
    finish_rsp();

    req(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("st_nostrb_err", er, 0);
    finish_rsp();
    req(1'b0, 32'h43, 0, 4'h0, rd, er, lat);
    chk("ld43_unchanged", rd, 32'hDE22_BE44);
    finish_rsp();

    req(1'b0, 32'h4000, 0, 4'h0, rd, er, lat);
    chk("oob_ld_err", er, 1);
    chk("oob_ld_rdata", rd, 0);
    finish_rsp();
    req(1'b1, 32'h4000, 32'h5555_5555, 4'hF, rd, er, lat);
    chk("oob_st_err", er, 1);
    finish_rsp();
    req(1'b0, 32'h0, 0, 4'h0, rd, er, lat);
    chk("word0_intact", rd, 32'h0BAD_F00D);
    chk("word0_err", er, 0);
    finish_rsp();

    // Backpressure: response must hold while rsp_ready stays low.
    req(1'b0, 32'h40, 0, 4'h0, hold_rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, 32'hDE22_BE44);
      chk("hold_err", o_rsp_err, 0);
      chk("hold_req_ready", o_req_ready, 0);
    end
    finish_rsp();

    req(1'b1, TOHOST_ADDR_DEF, 32'h1, 4'hF, rd, er, lat);
    chk("th1_halt", o_halt, 1);
    chk("th1_code", o_halt_code, 32'h1);
    chk("th1_err", er, 0);
    finish_rsp();
    req(1'b1, TOHOST_ADDR_DEF, 32'h7, 4'hF, rd, er, lat);
    chk("th2_code", o_halt_code, 32'h1);
    finish_rsp();
    req(1'b0, TOHOST_ADDR_DEF, 0, 4'h0, rd, er, lat);
    chk("th_ld_rdata", rd, 32'h1);
    chk("th_ld_err", er, 0);
    finish_rsp();

    // N=3 instance: set halt, then reset in the middle of a store's wait.
    use_b = 1'b1;
    req(1'b1, TOHOST_ADDR_DEF, 32'h9, 4'hF, rd, er, lat);
    chk("b_latency", lat, 4);
    chk("b_halt_set", o_halt, 1);
    finish_rsp();
    @(negedge clk);
    drv_valid = 1'b1; drv_we = 1'b1; drv_addr = 32'h14;
    drv_wdata = 32'hFFFF_FFFF; drv_wstrb = 4'hF;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #2;
    reset_b = 1'b1;
    #1;
    chk("rstmid_rsp_valid", o_rsp_valid, 0);
    chk("rstmid_halt", o_halt, 0);
    chk("rstmid_halt_code", o_halt_code, 0);
    chk("rstmid_req_ready", o_req_ready, 1);
    @(negedge clk);
    reset_b = 1'b0;
    req(1'b0, 32'h14, 0, 4'h0, rd, er, lat);
    chk("rstmid_old_data", rd, 32'hCAFE_0005);
    finish_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
